// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Issue/writeback stage wrapped around an external 16-bit combinational ALU.
// Decodes an instruction, reads its operands from an internal register file
// (with single-level forwarding from the instruction currently in EX), holds
// operands/op in EX registers for the ALU, then writes the ALU result back
// and publishes it one cycle later.
//
// Ports:
//   in_clk            clock, all state on rising edge
//   in_rst_n          asynchronous active-low reset
//   in_instr          instruction word: [15:14] op, [13:11] rd, [10:8] rs1,
//                     [7] imm, [6:4] rs2 (imm=0) or [6:0] signed immediate
//   in_instr_valid    instruction present
//   out_instr_ready   stage can accept (not stalled, not in reset)
//   in_stall          freezes EX, regfile and writeback
//   out_operand_1/2   registered ALU operands
//   out_alu_op_sel    registered ALU op (0 add, 1 sub, 2 and, 3 or)
//   in_alu_result     combinational ALU result for the EX registers
//   out_result        last written-back result
//   out_result_rd     destination register of out_result
//   out_result_valid  one-cycle pulse per written-back result
module alu_issue_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int IMM_W  = 7
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [15:0]       in_instr,
  input  logic              in_instr_valid,
  output logic              out_instr_ready,
  input  logic              in_stall,
  output logic [DATA_W-1:0] out_operand_1,
  output logic [DATA_W-1:0] out_operand_2,
  output logic [1:0]        out_alu_op_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  output logic [DATA_W-1:0] out_result,
  output logic [2:0]        out_result_rd,
  output logic              out_result_valid
);

  logic [DATA_W-1:0] r_regs [NREGS];

  logic [DATA_W-1:0] r_operand1;
  logic [DATA_W-1:0] r_operand2;
  logic [1:0]        r_opSel;
  logic              r_exValid;
  logic [2:0]        r_exRd;

  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_resultRd;
  logic              r_resultValid;

  logic [1:0]        w_op;
  logic [2:0]        w_rd;
  logic [2:0]        w_rs1;
  logic [2:0]        w_rs2;
  logic              w_imm;
  logic [DATA_W-1:0] w_immExt;
  logic [DATA_W-1:0] w_rs1Data;
  logic [DATA_W-1:0] w_rs2Data;
  logic              w_fwd1;
  logic              w_fwd2;
  logic [DATA_W-1:0] w_opnd1;
  logic [DATA_W-1:0] w_opnd2;
  logic              w_ready;
  logic              w_accept;
  logic              w_writeback;

  assign w_op  = in_instr[15:14];
  assign w_rd  = in_instr[13:11];
  assign w_rs1 = in_instr[10:8];
  assign w_imm = in_instr[7];
  assign w_rs2 = in_instr[6:4];

  assign w_immExt = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};

  // r0 is hardwired to zero on the read side as well as never being written
  assign w_rs1Data = (w_rs1 == 3'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2Data = (w_rs2 == 3'd0) ? '0 : r_regs[w_rs2];

  // The EX instruction's result has not reached the regfile yet, so a
  // dependent instruction takes it straight from the ALU output
  assign w_fwd1 = r_exValid && (r_exRd != 3'd0) && (r_exRd == w_rs1);
  assign w_fwd2 = r_exValid && (r_exRd != 3'd0) && !w_imm && (r_exRd == w_rs2);

  assign w_opnd1 = w_fwd1 ? in_alu_result : w_rs1Data;
  assign w_opnd2 = w_imm ? w_immExt : (w_fwd2 ? in_alu_result : w_rs2Data);

  assign w_ready     = in_rst_n && !in_stall;
  assign w_accept    = in_instr_valid && w_ready;
  assign w_writeback = r_exValid && !in_stall;

  // Register file: the EX instruction writes back when the pipe moves;
  // writes aimed at r0 are dropped
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_writeback && (r_exRd != 3'd0)) begin
      r_regs[r_exRd] <= in_alu_result;
    end
  end

  // EX registers: operands only change on accept so the ALU inputs stay
  // quiet while idle and stay valid for forwarding while stalled
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_opSel    <= '0;
      r_exRd     <= '0;
      r_exValid  <= 1'b0;
    end else if (!in_stall) begin
      r_exValid <= w_accept;
      if (w_accept) begin
        r_operand1 <= w_opnd1;
        r_operand2 <= w_opnd2;
        r_opSel    <= w_op;
        r_exRd     <= w_rd;
      end
    end
  end

  // Writeback publication: result/rd hold between writebacks, the valid
  // flag pulses once per retired instruction and is low during a stall
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_result      <= '0;
      r_resultRd    <= '0;
      r_resultValid <= 1'b0;
    end else begin
      r_resultValid <= w_writeback;
      if (w_writeback) begin
        r_result   <= in_alu_result;
        r_resultRd <= r_exRd;
      end
    end
  end

  assign out_instr_ready  = w_ready;
  assign out_operand_1    = r_operand1;
  assign out_operand_2    = r_operand2;
  assign out_alu_op_sel   = r_opSel;
  assign out_result       = r_result;
  assign out_result_rd    = r_resultRd;
  assign out_result_valid = r_resultValid;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instrValid;
  logic        stall;
  logic        instrReady;
  logic [15:0] operand1;
  logic [15:0] operand2;
  logic [1:0]  opSel;
  logic [15:0] aluResult;
  logic [15:0] result;
  logic [2:0]  resultRd;
  logic        resultValid;

  int checks = 0;
  int errors = 0;

  // Instruction-level reference model state
  logic [15:0] arch [8];
  bit          pendValid;
  logic [15:0] pendRes;
  logic [2:0]  pendRd;
  logic [15:0] lastA;
  logic [15:0] lastB;
  logic [1:0]  lastOp;
  logic [15:0] lastRes;
  logic [2:0]  lastRd;
  bit          expValid;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .in_clk           (clk),
    .in_rst_n         (rst_n),
    .in_instr         (instr),
    .in_instr_valid   (instrValid),
    .out_instr_ready  (instrReady),
    .in_stall         (stall),
    .out_operand_1    (operand1),
    .out_operand_2    (operand2),
    .out_alu_op_sel   (opSel),
    .in_alu_result    (aluResult),
    .out_result       (result),
    .out_result_rd    (resultRd),
    .out_result_valid (resultValid)
  );

  // External combinational ALU driven by the stage's EX registers
  always_comb begin
    aluResult = '0;
    case (opSel)
      2'd0: aluResult = operand1 + operand2;
      2'd1: aluResult = operand1 - operand2;
      2'd2: aluResult = operand1 & operand2;
      default: aluResult = operand1 | operand2;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sext7(input logic [6:0] f);
    int v;
    v = int'(f);
    if (v > 63) v = v - 128;
    return 16'(v);
  endfunction

  function automatic logic [15:0] refAlu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned x;
    int unsigned ua;
    int unsigned ub;
    ua = a;
    ub = b;
    case (op)
      2'd0: x = (ua + ub) % 65536;
      2'd1: x = (ua + 65536 - ub) % 65536;
      2'd2: x = ua & ub;
      default: x = ua | ub;
    endcase
    return 16'(x);
  endfunction

  function automatic logic [15:0] encR(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] encI(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1, input int imm);
    logic [6:0] f;
    f = 7'(imm);
    return {op, rd, rs1, 1'b1, f};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) arch[i] = '0;
    pendValid = 0;
    pendRes   = '0;
    pendRd    = '0;
    lastA     = '0;
    lastB     = '0;
    lastOp    = '0;
    lastRes   = '0;
    lastRd    = '0;
    expValid  = 0;
  endtask

  // One clock cycle: drive, predict in program order, then check after the edge
  task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic st);
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    @(negedge clk);
    instrValid = v;
    instr      = ins;
    stall      = st;
    #1;
    checkOutput("ready", instrReady, !st);
    expValid = 0;
    if (!st) begin
      if (pendValid) begin
        expValid = 1;
        lastRes  = pendRes;
        lastRd   = pendRd;
      end
      pendValid = 0;
      if (v) begin
        op  = ins[15:14];
        rd  = ins[13:11];
        a   = arch[ins[10:8]];
        b   = ins[7] ? sext7(ins[6:0]) : arch[ins[6:4]];
        res = refAlu(op, a, b);
        if (rd != 3'd0) arch[rd] = res;
        pendValid = 1;
        pendRes   = res;
        pendRd    = rd;
        lastA     = a;
        lastB     = b;
        lastOp    = op;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("result_valid", resultValid, expValid);
    checkOutput("result", result, lastRes);
    checkOutput("result_rd", resultRd, lastRd);
    checkOutput("operand_1", operand1, lastA);
    checkOutput("operand_2", operand2, lastB);
    checkOutput("alu_op_sel", opSel, lastOp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, instrReady, 0);
    checkOutput({tag, "_valid"}, resultValid, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_rd"}, resultRd, 0);
    checkOutput({tag, "_op1"}, operand1, 0);
    checkOutput({tag, "_op2"}, operand2, 0);
    checkOutput({tag, "_opsel"}, opSel, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    instrValid = 1'b0;
    stall      = 1'b0;
    instr      = '0;
    modelReset();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Two immediate adds, one positive and one negative
    applyStimulus(1, encI(2'd0, 3'd1, 3'd0, 5), 0);
    applyStimulus(1, encI(2'd0, 3'd2, 3'd0, -3), 0);
    checkOutput("addi5_result", result, 16'h0005);
    checkOutput("addi5_rd", resultRd, 1);
    applyStimulus(0, 16'h0000, 0);
    checkOutput("addim3_result", result, 16'hFFFD);
    checkOutput("addim3_rd", resultRd, 2);
    applyStimulus(0, 16'h0000, 0);

    // Back-to-back dependency through forwarding
    applyStimulus(1, encI(2'd0, 3'd1, 3'd0, 10), 0);
    applyStimulus(1, encR(2'd0, 3'd2, 3'd1, 3'd1), 0);
    applyStimulus(0, 16'h0000, 0);
    checkOutput("fwd_result", result, 16'h0014);
    checkOutput("fwd_valid", resultValid, 1);
    applyStimulus(0, 16'h0000, 0);

    // Subtract wrap, then AND/OR with an immediate
    applyStimulus(1, encI(2'd0, 3'd1, 3'd0, 1), 0);
    applyStimulus(1, encR(2'd1, 3'd3, 3'd0, 3'd1), 0);
    applyStimulus(1, encI(2'd2, 3'd4, 3'd3, 63), 0);
    checkOutput("sub_wrap", result, 16'hFFFF);
    applyStimulus(1, encI(2'd3, 3'd5, 3'd3, 63), 0);
    checkOutput("and_imm", result, 16'h003F);
    applyStimulus(0, 16'h0000, 0);
    checkOutput("or_imm", result, 16'hFFFF);
    applyStimulus(0, 16'h0000, 0);

    // r0 write is published but discarded
    applyStimulus(1, encI(2'd0, 3'd0, 3'd0, 7), 0);
    applyStimulus(1, encR(2'd0, 3'd4, 3'd0, 3'd0), 0);
    checkOutput("r0_write_result", result, 16'h0007);
    checkOutput("r0_write_valid", resultValid, 1);
    applyStimulus(0, 16'h0000, 0);
    checkOutput("r0_read_result", result, 16'h0000);
    applyStimulus(0, 16'h0000, 0);

    // Stall holds the EX instruction for three cycles
    applyStimulus(1, encI(2'd0, 3'd5, 3'd0, 9), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, encI(2'd0, 3'd6, 3'd0, 1), 1);
    checkOutput("stall_op2_held", operand2, 16'h0009);
    applyStimulus(0, 16'h0000, 0);
    checkOutput("stall_release_result", result, 16'h0009);
    checkOutput("stall_release_rd", resultRd, 5);
    applyStimulus(0, 16'h0000, 0);

    // Randomized traffic with stalls
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 4) == 0);
    end
    applyStimulus(0, 16'h0000, 0);
    applyStimulus(0, 16'h0000, 0);

    // Asynchronous reset mid-cycle while EX holds an instruction
    applyStimulus(1, encI(2'd0, 3'd6, 3'd0, 12), 0);
    @(negedge clk);
    instrValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("reset_no_wb", resultValid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, encR(2'd0, 3'd7, 3'd5, 3'd6), 0);
    applyStimulus(1, encR(2'd3, 3'd1, 3'd3, 3'd2), 0);
    checkOutput("regfile_cleared_a", result, 16'h0000);
    applyStimulus(0, 16'h0000, 0);
    checkOutput("regfile_cleared_b", result, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
